// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one operand bit per clock, LSB first, with a
// start/busy/done handshake around a two-half-adder full-adder cell.

module serial_adder_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, psum, psum_nxt;
  logic [WIDTH:0]   psum_cat;
  logic [CW-1:0]    cnt;
  logic             carry, carry_nxt;
  logic             s0, c0, c1, bit_s;
  logic             last, accept;

  serial_adder_ha u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(s0),    .c(c0));
  serial_adder_ha u_ha1 (.x(s0),      .y(carry),   .s(bit_s), .c(c1));

  assign carry_nxt = c0 | c1;
  assign psum_cat  = {bit_s, psum};
  assign psum_nxt  = psum_cat[WIDTH:1];
  assign last      = (cnt == LAST);
  // DONE accepts a new request just like IDLE, so back-to-back ops lose no cycle
  assign accept    = start && (state != SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= c_in;
      psum  <= '0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      psum  <= psum_nxt;
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum   <= psum_nxt;
        c_out <= carry_nxt;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table-driven vectors with a result
// scoreboard, plus hand sequences for the multi-cycle corner cases.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8));

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic [7:0] sum;
    logic       c_out;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       c_out;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one request on the 8-bit DUT for one edge and record its result.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci, input bit push);
    exp_t e;
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    if (push) begin
      e.sum = a + b + {7'b0, ci};
      e.c_out = ({1'b0, a} + {1'b0, b} + {8'b0, ci}) > 9'd255;
      sbq.push_back(e);
    end
    step();
    start8 = 1'b0;
  endtask

  // Sit through the SHIFT phase (optionally poking inputs), then score the result.
  task automatic wait_done8(input string name, input bit noise);
    int   cyc = 0;
    bit   stable = 1;
    logic [7:0] s0 = sum8;
    logic       c0 = cout8;
    exp_t e;
    while (busy8 && cyc < 40) begin
      if (sum8 !== s0 || cout8 !== c0 || done8) stable = 0;
      if (noise) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'($urandom);
      end
      cyc++;
      step();
    end
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    chk({name, " busy cycles"}, cyc, 8);
    chk({name, " result held during shift"}, stable, 1);
    chk({name, " done"}, done8, 1);
    if (sbq.size() == 0) begin
      chk({name, " scoreboard empty"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({name, " sum"}, sum8, e.sum);
      chk({name, " c_out"}, cout8, e.c_out);
    end
  endtask

  task automatic op1(input logic a, input logic b, input logic ci, input logic es, input logic ec);
    a1 = a; b1 = b; cin1 = ci; start1 = 1'b1;
    step();
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    chk("w1 busy after accept", busy1, 1);
    step();
    chk("w1 done", {busy1, done1}, 2'b01);
    chk("w1 sum", sum1, es);
    chk("w1 c_out", cout1, ec);
    step();
    chk("w1 idle after done", {busy1, done1}, 2'b00);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

    rst = 1'b1; start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    step(); step();
    rst = 1'b0;
    chk("reset outputs", {busy8, done8, sum8, cout8}, 11'h0);
    repeat (5) step();
    chk("idle hold", {busy8, done8, sum8, cout8}, 11'h0);

    // Table vectors; the table's expected values double-check the scoreboard model.
    for (int i = 0; i < 6; i++) begin
      issue8(vecs[i].a, vecs[i].b, vecs[i].c_in, 1);
      wait_done8($sformatf("vec%0d", i), 0);
      chk($sformatf("vec%0d table sum", i), sum8, vecs[i].sum);
      chk($sformatf("vec%0d table c_out", i), cout8, vecs[i].c_out);
      step();
      chk($sformatf("vec%0d done one cycle", i), {busy8, done8}, 2'b00);
      if (i == 0) begin
        repeat (9) step();
        chk("sum held ten cycles", sum8, 8'h10);
      end
    end

    // Inputs and start toggled while busy must not disturb or queue anything.
    issue8(8'h12, 8'h34, 1'b0, 1);
    wait_done8("noise", 1);
    chk("noise sum", sum8, 8'h46);
    step();
    chk("noise no second op", {busy8, done8}, 2'b00);
    repeat (3) step();
    chk("noise still idle", {busy8, done8, sum8}, {2'b00, 8'h46});

    // Back-to-back: the request in the DONE cycle starts immediately.
    issue8(8'h0F, 8'h01, 1'b0, 1);
    wait_done8("b2b first", 0);
    issue8(8'h80, 8'h80, 1'b0, 1);
    chk("b2b busy immediately", busy8, 1);
    wait_done8("b2b second", 0);
    chk("b2b second sum", {cout8, sum8}, 9'h100);
    step();

    // Reset on the 4th SHIFT cycle aborts with no done pulse.
    issue8(8'h3C, 8'hC3, 1'b0, 1);
    wait_done8("pre-reset", 0);
    step();
    issue8(8'h55, 8'h11, 1'b0, 0);
    repeat (3) step();
    chk("mid shift busy", busy8, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort outputs", {busy8, done8, sum8, cout8}, 11'h0);
    begin
      bit saw_done = 0;
      repeat (12) begin
        if (done8 || busy8) saw_done = 1;
        step();
      end
      chk("abort no done", saw_done, 0);
    end
    issue8(8'h01, 8'h01, 1'b0, 1);
    wait_done8("after reset", 0);
    chk("after reset sum", sum8, 8'h02);
    step();

    // WIDTH=1 instance.
    op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    op1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    op1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    chk("scoreboard drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
